// File: rtl/seq_issue_packer.sv
// Sequence-load issuer: packs a header plus a serial stream of 2-bit bases into the score bank's load word.
// Optional build macro SEQ_OVF_DROP_EN discards overflowed sequences instead of issuing them truncated.
module seq_issue_packer #(
  parameter int          ID_WIDTH      = 48,
  parameter int          LEN_WIDTH     = 12,
  parameter int          TARGET_LENGTH = 128,
  parameter int          SCORE_WIDTH   = 12,
  parameter logic [1:0]  PAD_BASE      = 2'b00,
  parameter int          IN_WIDTH      = 2 + ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH,
  parameter int          CNT_WIDTH     = $clog2(TARGET_LENGTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hdr_valid,
  output logic                       hdr_ready,
  input  logic                       hdr_is_query,
  input  logic [ID_WIDTH-1:0]        hdr_id,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [1:0]                 s_base,
  input  logic                       s_last,
  input  logic                       bank_full,
  output logic                       ld_sequence,
  output logic [0:IN_WIDTH-1]        data_out,
  input  logic                       cfg_we,
  input  logic [4*SCORE_WIDTH-1:0]   cfg_penalties,
  output logic [4*SCORE_WIDTH-1:0]   penalties,
  output logic                       ld_penalties,
  output logic                       busy,
  output logic                       err_ovf
);

  localparam int LEN_OFF = 2 + ID_WIDTH;
  localparam int SEQ_OFF = 2 + ID_WIDTH + LEN_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  is_query;
  logic                  is_query_next;
  logic                  seq_ovf;
  logic                  seq_ovf_next;
  logic                  err_ovf_next;
  logic [0:IN_WIDTH-1]   data_next;
  logic                  hdr_fire;
  logic                  beat_fire;
  logic                  room;
  logic                  drop_seq;

  // Handshakes use the registered ready flags, so they can only fire in the matching state.
  assign hdr_fire  = hdr_valid & hdr_ready;
  assign beat_fire = s_valid & s_ready;
  assign room      = (count < CNT_WIDTH'(TARGET_LENGTH));

  // Next-state and next-datapath computation for the packing FSM.
  always_comb begin
    state_next    = state;
    count_next    = count;
    is_query_next = is_query;
    seq_ovf_next  = seq_ovf;
    err_ovf_next  = err_ovf;
    data_next     = data_out;
    drop_seq      = 1'b0;

    case (state)
      IDLE: begin
        if (hdr_fire) begin
          is_query_next                    = hdr_is_query;
          seq_ovf_next                     = 1'b0;
          count_next                       = '0;
          data_next[0]                     = ~hdr_is_query;
          data_next[1]                     = hdr_is_query;
          data_next[2 +: ID_WIDTH]         = hdr_id;
          data_next[LEN_OFF +: LEN_WIDTH]  = '0;
          for (int k = 0; k < TARGET_LENGTH; k++) begin
            data_next[SEQ_OFF + 2*k +: 2] = PAD_BASE;
          end
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end

      FILL: begin
        if (beat_fire) begin
          if (room) begin
            data_next[SEQ_OFF + 2*int'(count) +: 2] = s_base;
            // The length field tracks the count so the word is already final when WAIT begins.
            data_next[LEN_OFF +: LEN_WIDTH]         = LEN_WIDTH'(count) + LEN_WIDTH'(1);
            count_next                              = count + CNT_WIDTH'(1);
          end else begin
            seq_ovf_next = 1'b1;
            err_ovf_next = 1'b1;
          end
`ifdef SEQ_OVF_DROP_EN
          drop_seq = seq_ovf_next;
`else
          drop_seq = 1'b0;
`endif
          if (s_last) begin
            if (drop_seq) begin
              state_next = IDLE;
            end else begin
              state_next = WAIT;
            end
          end else begin
            state_next = FILL;
          end
        end else begin
          state_next = FILL;
        end
      end

      WAIT: begin
        // Queries bypass the bank's target-full throttle.
        if (is_query || !bank_full) begin
          state_next = ISSUE;
        end else begin
          state_next = WAIT;
        end
      end

      ISSUE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, packing datapath and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      is_query <= 1'b0;
      seq_ovf  <= 1'b0;
      err_ovf  <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      is_query <= is_query_next;
      seq_ovf  <= seq_ovf_next;
      err_ovf  <= err_ovf_next;
      data_out <= data_next;
    end
  end

  // Registered handshake and status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_ready   <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      ld_sequence <= 1'b0;
    end else begin
      hdr_ready   <= (state_next == IDLE);
      s_ready     <= (state_next == FILL);
      busy        <= (state_next != IDLE);
      ld_sequence <= (state_next == ISSUE);
    end
  end

  // Penalty configuration register and its load strobe, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      penalties    <= '0;
      ld_penalties <= 1'b0;
    end else begin
      if (cfg_we) begin
        penalties <= cfg_penalties;
      end else begin
        penalties <= penalties;
      end
      ld_penalties <= cfg_we;
    end
  end

endmodule
